fpu_fmul_unit: RTL and testbench
================================

# fpu_fmul_unit

Multi-cycle single-precision floating-point multiplier that sits behind the execute-stage ALU and answers its FP requests. The ALU side presents `alu_control`, `src_a` and `src_b` with a `start` strobe. This block holds `fpu_ready` low while it computes and returns `fpu_result` with a one-cycle `fpu_done` pulse. It provides the real responder end of the `fpu_ready` handshake, so the hazard unit can stall EX on multi-cycle FP ops.

## Interface
- No parameters. Latency and encodings are fixed constants in `fpu_pkg`.
- `clk`  in  1  Rising-edge clock.
- `rst`  in  1  Asynchronous, active-high reset.
- `start`  in  1  Request strobe from EX. Sampled only while `fpu_ready`=1.
- `alu_control`  in  5  Operation code. FP ops have bit 4 set; FMUL = 5'b10010.
- `src_a`  in  32  Operand A, IEEE-754 binary32.
- `src_b`  in  32  Operand B, IEEE-754 binary32.
- `fpu_result`  out  32  Result. Valid while `fpu_done`=1 and held until the next accept.
- `fpu_ready`  out  1  High when a new request can be accepted.
- `fpu_done`  out  1  One-cycle pulse: `fpu_result` is valid.

## Operation
- Accept condition: `start & fpu_ready & alu_control[4]`. Operands and opcode are captured on the accept edge; later input changes are ignored.
- `start` with `alu_control[4]`=0 is ignored.
- FSM states are IDLE, MUL, NORM, DONE.
  - IDLE→MUL on accept of FMUL.
  - IDLE→DONE on accept of any other FP code. The result is then 32'h0 (unsupported op).
  - MUL→NORM unconditionally.
  - NORM→DONE unconditionally.
  - DONE→MUL or DONE on a new accept (back-to-back is allowed), else DONE→IDLE.
- MUL stage registers the following:
  - sign = a[31]^b[31]
  - 10-bit signed esum = ea+eb-127
  - 48-bit product P = {1,ma}×{1,mb}
  - special-case flags
- Special cases are resolved in priority order:
  - Either exponent = 255 with the other operand zero (exp = 0) gives 32'h7FC00000.
  - Otherwise, either exponent = 255 gives {sign, 8'hFF, 23'h0}.
  - Otherwise, either exponent = 0 gives {sign, 31'h0}. Denormals are flushed to zero and no denormals are produced.
- NORM stage applies normalization:
  - If P[47]=1: mant = P[46:24], guard = P[23], sticky = |P[22:0], exp = esum+1.
  - Otherwise: mant = P[45:23], guard = P[22], sticky = |P[21:0], exp = esum.
- Rounding is round-to-nearest-even: increment when `guard & (sticky | mant[0])`. If the increment carries out of the mantissa, then exp+1 and mant = 0.
- Range checks after rounding:
  - exp ≥ 255 gives signed infinity.
  - exp ≤ 0 gives signed zero.
  - Otherwise the result is {sign, exp[7:0], mant}.
- No exception flags.

## Timing
- Reset values:
  - state = IDLE
  - `fpu_ready` = 1
  - `fpu_done` = 0
  - `fpu_result` = 32'h0
  - internal pipeline registers = 0
- `fpu_ready` = (state==IDLE) | (state==DONE). It is a registered-state decode with no combinational path from `start`.
- FMUL latency is 3 cycles:
  - accept at edge N
  - `fpu_done`=1 during cycle N+3
  - `fpu_ready` low during cycles N+1 and N+2
- Unsupported FP code: `fpu_done` during cycle N+1, result 0.
- `fpu_done` is never asserted for two consecutive cycles, except when a new accept occurs during DONE of an unsupported op.
- `rst` asserted mid-operation has immediate effect. The block returns to IDLE, outputs take reset values, and the in-flight result is discarded with no `fpu_done`.
- Simultaneous `start` during DONE: the current result is still presented that cycle, and the new request is captured on the same edge.

## Structure
- `fpu_pkg` holds the following:
  - opcode constants FP_OP_FMUL = 5'b10010
  - FP_CANON_NAN = 32'h7FC00000
  - FP_EXP_BIAS = 127
  - state encoding (IDLE/MUL/NORM/DONE)
- One combinational sub-module, `fmul_round`. It takes sign, 10-bit exp, 48-bit P and the special flags, and returns the packed 32-bit result. This gives the NORM logic a separate unit test.

## Test plan
- Basic product, after reset: FMUL a=32'h40000000 (2.0), b=32'h40400000 (3.0) → `fpu_done` 3 cycles after accept, result 32'h40C00000. `fpu_ready` is low exactly 2 cycles.
- Rounding and sign cases:
  - a = b = 32'h3FC00000 → 32'h40100000.
  - a = b = 32'h3F800001 → 32'h3F800002 (guard 0, sticky 1: no round-up).
  - a=32'hBF800000, b=32'h00000000 → 32'h80000000.
- Overflow and NaN:
  - a = b = 32'h7F000000 → 32'h7F800000.
  - a=32'h7F800000, b=32'h00000000 → 32'h7FC00000.
- Handshake:
  - Two FMULs issued back-to-back, the second with `start` in the DONE cycle → second `fpu_done` 3 cycles later with no idle gap.
  - `start` while `fpu_ready`=0 is ignored, and the first result is unchanged.
- Unsupported code and non-FP code:
  - `alu_control`=5'b10100 → `fpu_done` the next cycle with result 0.
  - `alu_control`=5'b00010 with `start` → no accept, `fpu_ready` stays 1.
- Reset mid-operation: assert `rst` asynchronously in NORM → `fpu_ready`=1, `fpu_result`=0 immediately, with no `fpu_done` afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants, state encoding and special-case flag bundle for the FP multiplier.
package fpu_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned PROD_W = 48;

  localparam logic [4:0]      FP_OP_FMUL   = 5'b10010;
  localparam logic [FP_W-1:0] FP_CANON_NAN = 32'h7FC00000;
  localparam int unsigned     FP_EXP_BIAS  = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } fpu_state_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fmul_special_t;

endpackage

// File: rtl/fmul_round.sv
// Normalize, round-to-nearest-even and range-check a raw 48-bit mantissa product.
module fmul_round
  import fpu_pkg::*;
(
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  esum_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              nan_i,
  input  logic              inf_i,
  input  logic              zero_i,
  output logic [FP_W-1:0]   result_o
);

  logic [22:0]        mant;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [23:0]        mant_sum;
  logic signed [10:0] e_norm;
  logic signed [10:0] e_fin;

  always_comb begin
    if (prod_i[47]) begin
      mant   = prod_i[46:24];
      guard  = prod_i[23];
      sticky = |prod_i[22:0];
      e_norm = $signed({esum_i[9], esum_i}) + 11'sd1;
    end else begin
      mant   = prod_i[45:23];
      guard  = prod_i[22];
      sticky = |prod_i[21:0];
      e_norm = $signed({esum_i[9], esum_i});
    end
    round_up = guard & (sticky | mant[0]);
    // A carry out of the mantissa leaves mant_sum[22:0] at zero, so only the exponent moves.
    mant_sum = {1'b0, mant} + 24'(round_up);
    e_fin    = e_norm + $signed({10'd0, mant_sum[23]});

    if (nan_i) begin
      result_o = FP_CANON_NAN;
    end else if (inf_i) begin
      result_o = {sign_i, 8'hFF, 23'h0};
    end else if (zero_i) begin
      result_o = {sign_i, 31'h0};
    end else if (e_fin >= 11'sd255) begin
      result_o = {sign_i, 8'hFF, 23'h0};
    end else if (e_fin <= 11'sd0) begin
      result_o = {sign_i, 31'h0};
    end else begin
      result_o = {sign_i, e_fin[7:0], mant_sum[22:0]};
    end
  end

endmodule

// File: rtl/fpu_fmul_unit.sv
// Multi-cycle binary32 multiplier answering EX-stage FP requests over a ready/done handshake.
module fpu_fmul_unit
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] fpu_result,
  output logic        fpu_ready,
  output logic        fpu_done
);

  fpu_state_e          state_q, state_d;
  logic [FP_W-1:0]     a_q, a_d;
  logic [FP_W-1:0]     b_q, b_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    esum_q, esum_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  fmul_special_t       spec_q, spec_d;
  logic [FP_W-1:0]     result_q, result_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic                accept_c;
  logic                is_fmul_c;
  logic [FP_W-1:0]     round_result_c;
  logic                a_inf_c, b_inf_c, a_zero_c, b_zero_c;

  assign accept_c  = start & ready_q & alu_control[4];
  assign is_fmul_c = (alu_control == FP_OP_FMUL);

  assign fpu_result = result_q;
  assign fpu_ready  = ready_q;
  assign fpu_done   = done_q;

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      esum_q   <= '0;
      prod_q   <= '0;
      spec_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      esum_q   <= esum_d;
      prod_q   <= prod_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = is_fmul_c ? ST_MUL : ST_DONE;
      ST_MUL:  state_d = ST_NORM;
      ST_NORM: state_d = ST_DONE;
      ST_DONE: begin
        if (accept_c) state_d = is_fmul_c ? ST_MUL : ST_DONE;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_inf_c  = (a_q[30:23] == 8'hFF);
  assign b_inf_c  = (b_q[30:23] == 8'hFF);
  assign a_zero_c = (a_q[30:23] == 8'h00);
  assign b_zero_c = (b_q[30:23] == 8'h00);

  fmul_round u_round (
    .sign_i   (sign_q),
    .esum_i   (esum_q),
    .prod_i   (prod_q),
    .nan_i    (spec_q.nan),
    .inf_i    (spec_q.inf),
    .zero_i   (spec_q.zero),
    .result_o (round_result_c)
  );

  // Datapath and output register inputs.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    esum_d   = esum_q;
    prod_d   = prod_q;
    spec_d   = spec_q;
    result_d = result_q;
    done_d   = (state_d == ST_DONE);
    ready_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);

    if (accept_c) begin
      a_d = src_a;
      b_d = src_b;
    end

    if (state_q == ST_MUL) begin
      sign_d      = a_q[31] ^ b_q[31];
      esum_d      = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - EXP_W'(FP_EXP_BIAS);
      prod_d      = PROD_W'({1'b1, a_q[22:0]}) * PROD_W'({1'b1, b_q[22:0]});
      spec_d.nan  = (a_inf_c & b_zero_c) | (b_inf_c & a_zero_c);
      spec_d.inf  = a_inf_c | b_inf_c;
      spec_d.zero = a_zero_c | b_zero_c;
    end

    // Entering DONE from anywhere but NORM means an unsupported FP code was accepted.
    if (state_d == ST_DONE) begin
      result_d = (state_q == ST_NORM) ? round_result_c : '0;
    end
  end

endmodule

// File: tb/tb_fpu_fmul_unit.sv
// Directed and randomized checks of fpu_fmul_unit against an integer-arithmetic reference model.
module tb_fpu_fmul_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  alu_control = 5'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic [31:0] fpu_result;
  logic        fpu_ready;
  logic        fpu_done;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [4:0] OP_FMUL = 5'b10010;

  fpu_fmul_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .fpu_result  (fpu_result),
    .fpu_ready   (fpu_ready),
    .fpu_done    (fpu_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start       = s;
    alu_control = op;
    src_a       = a;
    src_b       = b;
  endtask

  // Reference: exact integer product, rounded by comparing the discarded remainder to one half.
  function automatic logic [31:0] ref_fmul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                ea, eb, e, sh;
    longint unsigned   p, q, rem, half;
    logic [31:0]       ev;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC00000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e  = ea + eb - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    ev = 32'(e);
    return {s, ev[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(1, 40));
      4, 5:    e = 8'($urandom_range(200, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Issue one FMUL at the current negedge and check the full 3-cycle handshake.
  task automatic fmul_check(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string tag);
    chk({tag, "_ready_pre"}, 32'(fpu_ready), 32'd1);
    drive(1'b1, OP_FMUL, a, b);
    step();
    drive(1'b0, OP_FMUL, $urandom, $urandom);
    chk({tag, "_busy1"}, {30'd0, fpu_ready, fpu_done}, 32'd0);
    step();
    chk({tag, "_busy2"}, {30'd0, fpu_ready, fpu_done}, 32'd0);
    step();
    chk({tag, "_done"}, {30'd0, fpu_ready, fpu_done}, 32'd3);
    chk({tag, "_result"}, fpu_result, exp);
    step();
    chk({tag, "_idle"}, {30'd0, fpu_ready, fpu_done}, 32'd2);
  endtask

  initial begin
    logic        saw_done;
    logic [31:0] ra, rb;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(fpu_ready), 32'd1);
    chk("rst_done", 32'(fpu_done), 32'd0);
    chk("rst_result", fpu_result, 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_idle", {fpu_result[29:0], fpu_ready, fpu_done}, 32'd2);

    fmul_check(32'h40000000, 32'h40400000, 32'h40C00000, "basic_2x3");
    fmul_check(32'h3FC00000, 32'h3FC00000, 32'h40100000, "r_1p5sq");
    fmul_check(32'h3F800001, 32'h3F800001, 32'h3F800002, "r_noround");
    fmul_check(32'h3FC00000, 32'h3F800001, 32'h3FC00002, "r_tie_up");
    fmul_check(32'hBF800000, 32'h00000000, 32'h80000000, "neg_zero");
    fmul_check(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
    fmul_check(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
    fmul_check(32'hFF800000, 32'h40000000, 32'hFF800000, "neg_inf");

    // Back-to-back: second request arrives in the DONE cycle of the first.
    drive(1'b1, OP_FMUL, 32'h3FC00000, 32'h3FC00000);
    step();
    drive(1'b0, OP_FMUL, 32'h0, 32'h0);
    step();
    step();
    chk("b2b_done1", 32'(fpu_done), 32'd1);
    chk("b2b_res1", fpu_result, 32'h40100000);
    drive(1'b1, OP_FMUL, 32'h40000000, 32'h40400000);
    step();
    drive(1'b0, OP_FMUL, 32'h0, 32'h0);
    chk("b2b_busy", {30'd0, fpu_ready, fpu_done}, 32'd0);
    chk("b2b_hold", fpu_result, 32'h40100000);
    step();
    step();
    chk("b2b_done2", 32'(fpu_done), 32'd1);
    chk("b2b_res2", fpu_result, 32'h40C00000);
    step();
    chk("b2b_end", 32'(fpu_done), 32'd0);

    // start while busy must be ignored.
    drive(1'b1, OP_FMUL, 32'h40000000, 32'h40400000);
    step();
    drive(1'b1, OP_FMUL, 32'h7F000000, 32'h7F000000);
    step();
    drive(1'b0, OP_FMUL, 32'h0, 32'h0);
    step();
    chk("busy_ign_done", 32'(fpu_done), 32'd1);
    chk("busy_ign_res", fpu_result, 32'h40C00000);
    step();
    chk("busy_ign_after", {30'd0, fpu_ready, fpu_done}, 32'd2);

    // Non-FP code is never accepted.
    drive(1'b1, 5'b00010, 32'h3F800000, 32'h3F800000);
    step();
    chk("nonfp_ready", {30'd0, fpu_ready, fpu_done}, 32'd2);
    drive(1'b0, 5'b00000, 32'h0, 32'h0);
    step();
    chk("nonfp_nodone", 32'(fpu_done), 32'd0);
    chk("nonfp_res", fpu_result, 32'h40C00000);

    // Unsupported FP codes, including one accepted during the DONE cycle of another.
    drive(1'b1, 5'b10100, 32'h40000000, 32'h40400000);
    step();
    chk("unsup_done", {30'd0, fpu_ready, fpu_done}, 32'd3);
    chk("unsup_res", fpu_result, 32'h0);
    drive(1'b1, 5'b10110, 32'h40000000, 32'h40400000);
    step();
    chk("unsup_b2b_done", 32'(fpu_done), 32'd1);
    drive(1'b0, 5'b00000, 32'h0, 32'h0);
    step();
    chk("unsup_end", {30'd0, fpu_ready, fpu_done}, 32'd2);

    fmul_check(32'h40000000, 32'h40400000, 32'h40C00000, "pre_rst");

    // Asynchronous reset during NORM discards the operation.
    drive(1'b1, OP_FMUL, 32'h3FC00000, 32'h3FC00000);
    step();
    drive(1'b0, OP_FMUL, 32'h0, 32'h0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(fpu_ready), 32'd1);
    chk("midrst_res", fpu_result, 32'h0);
    chk("midrst_done", 32'(fpu_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fpu_done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 32'(saw_done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      fmul_check(ra, rb, ref_fmul(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
